// File: rtl/sr_btn_conditioner_pkg.sv
// rtl/sr_btn_conditioner_pkg.sv - shared state encoding and default timing for the button conditioner
package sr_btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_PULSE_LEN  = 1;

endpackage

// File: rtl/sr_btn_conditioner_if.sv
// rtl/sr_btn_conditioner_if.sv - raw buttons in, s/r commands and status out
interface sr_btn_conditioner_if;
  logic set_btn;
  logic reset_btn;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  modport master (output set_btn, output reset_btn,
                  input s, input r, input busy, input conflict);
  modport slave  (input set_btn, input reset_btn,
                  output s, output r, output busy, output conflict);
endinterface

// File: rtl/sr_btn_conditioner_btn_debounce.sv
// rtl/sr_btn_conditioner_btn_debounce.sv - two-flop sync, debounce counter and press request
module btn_debounce
  import sr_btn_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic req
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign req    = stable_q & ~stable_prev_q;

endmodule

// File: rtl/sr_btn_conditioner.sv
// rtl/sr_btn_conditioner.sv - debounced buttons to mutually exclusive, gap-separated s/r pulses
module sr_btn_conditioner
  import sr_btn_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int PULSE_LEN      = DEF_PULSE_LEN,
  parameter bit RESET_PRIORITY = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  sr_btn_conditioner_if.slave  btn_if
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_LEN - 1);

  logic set_stable, set_req, reset_stable, reset_req;
  logic set_go, reset_go;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_set_deb (
    .clk(clk), .rst(rst), .btn_raw(btn_if.set_btn), .stable(set_stable), .req(set_req));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_reset_deb (
    .clk(clk), .rst(rst), .btn_raw(btn_if.reset_btn), .stable(reset_stable), .req(reset_req));

  assign set_go   = set_req & set_stable;
  assign reset_go = reset_req & reset_stable;

  state_e          state_q, state_d;
  logic            pend_s_q, pend_s_d, pend_r_q, pend_r_d;
  logic            conflict_q, conflict_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            s_q, r_q, busy_q;
  logic            want_s, want_r;

  always_comb begin
    state_d    = state_q;
    pend_s_d   = pend_s_q;
    pend_r_d   = pend_r_q;
    conflict_d = conflict_q;
    pcnt_d     = pcnt_q;
    want_s     = 1'b0;
    want_r     = 1'b0;
    case (state_q)
      // GAP dispatches like IDLE so a pending command starts right after the gap cycle
      ST_IDLE, ST_GAP: begin
        if (state_q == ST_IDLE && set_go && reset_go) begin
          conflict_d = 1'b1;
          want_s     = !RESET_PRIORITY;
          want_r     = RESET_PRIORITY;
        end else begin
          want_s = set_go | pend_s_q;
          want_r = reset_go | pend_r_q;
        end
        pcnt_d = '0;
        if (want_s && want_r) begin
          state_d  = RESET_PRIORITY ? ST_PULSE_R : ST_PULSE_S;
          pend_s_d = RESET_PRIORITY;
          pend_r_d = !RESET_PRIORITY;
        end else if (want_s) begin
          state_d  = ST_PULSE_S;
          pend_s_d = 1'b0;
        end else if (want_r) begin
          state_d  = ST_PULSE_R;
          pend_r_d = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        pend_s_d = pend_s_q | set_go;
        pend_r_d = pend_r_q | reset_go;
        if (pcnt_q == PCNT_LAST) begin
          state_d = ST_GAP;
          pcnt_d  = '0;
        end else begin
          pcnt_d  = pcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      conflict_q <= 1'b0;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      conflict_q <= conflict_d;
      pcnt_q     <= pcnt_d;
      s_q        <= (state_d == ST_PULSE_S);
      r_q        <= (state_d == ST_PULSE_R);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign btn_if.s        = s_q;
  assign btn_if.r        = r_q;
  assign btn_if.busy     = busy_q;
  assign btn_if.conflict = conflict_q;

endmodule

// File: tb/tb_sr_btn_conditioner.sv
// tb/tb_sr_btn_conditioner.sv - scoreboard bench for three parameterisations of sr_btn_conditioner
module tb_sr_btn_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_btn_conditioner_if ifa ();
  sr_btn_conditioner_if ifb ();
  sr_btn_conditioner_if ifc ();

  sr_btn_conditioner #(.DEB_CYCLES(4), .CNT_W(8), .PULSE_LEN(1), .RESET_PRIORITY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .btn_if(ifa));
  sr_btn_conditioner #(.DEB_CYCLES(4), .CNT_W(8), .PULSE_LEN(1), .RESET_PRIORITY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .btn_if(ifb));
  sr_btn_conditioner #(.DEB_CYCLES(4), .CNT_W(8), .PULSE_LEN(3), .RESET_PRIORITY(1'b1)) dut_c (
    .clk(clk), .rst(rst), .btn_if(ifc));

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int dut;
    int edge_no;
    bit is_r;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  logic [2:0] s_v, r_v;
  logic [2:0] s_p = 3'b000;
  logic [2:0] r_p = 3'b000;
  assign s_v = {ifc.s, ifb.s, ifa.s};
  assign r_v = {ifc.r, ifb.r, ifa.r};

  // Monitor: every high output cycle must match the head of the expectation queue
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ((s_v[d] & r_v[d]) | (s_p[d] & r_v[d]) | (r_p[d] & s_v[d])) begin
        fails++;
        $display("FAIL sr_exclusive dut%0d edge %0d: s=%b r=%b prev_s=%b prev_r=%b, required no overlap or adjacency",
                 d, edge_cnt, s_v[d], r_v[d], s_p[d], r_p[d]);
      end
      if (s_v[d] | r_v[d]) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pulse dut%0d edge %0d: got %s, required no pulse",
                   d, edge_cnt, r_v[d] ? "r" : "s");
        end else begin
          e = exp_q.pop_front();
          if (e.dut != d || e.edge_no != edge_cnt || e.is_r != r_v[d]) begin
            fails++;
            $display("FAIL pulse: got dut%0d %s at edge %0d, required dut%0d %s at edge %0d",
                     d, r_v[d] ? "r" : "s", edge_cnt, e.dut, e.is_r ? "r" : "s", e.edge_no);
          end
        end
      end
    end
    s_p <= s_v;
    r_p <= r_v;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input bit is_r, input int e0, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.dut = d;
      x.is_r = is_r;
      x.edge_no = e0 + i;
      exp_q.push_back(x);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ed;
  int rel;

  initial begin
    ifa.set_btn = 1'b0; ifa.reset_btn = 1'b0;
    ifb.set_btn = 1'b0; ifb.reset_btn = 1'b0;
    ifc.set_btn = 1'b0; ifc.reset_btn = 1'b0;
    rst = 1'b1;

    // Reset held three edges
    repeat (3) begin
      @(negedge clk);
      check("reset_a", {28'd0, ifa.s, ifa.r, ifa.busy, ifa.conflict}, 32'd0);
      check("reset_b", {28'd0, ifb.s, ifb.r, ifb.busy, ifb.conflict}, 32'd0);
      check("reset_c", {28'd0, ifc.s, ifc.r, ifc.busy, ifc.conflict}, 32'd0);
    end
    rst = 1'b0;
    cyc(5);

    // Single set press, long hold then release
    ed = edge_cnt + 1;
    ifa.set_btn = 1'b1;
    push(0, 1'b0, ed + 6, 1);
    cyc(12);
    ifa.set_btn = 1'b0;
    cyc(15);
    check("busy_a_idle", {31'd0, ifa.busy}, 32'd0);
    check("conflict_a_single", {31'd0, ifa.conflict}, 32'd0);

    // Short press and bounce produce nothing
    ifa.set_btn = 1'b1;
    cyc(3);
    ifa.set_btn = 1'b0;
    cyc(4);
    for (int i = 0; i < 20; i++) begin
      ifa.set_btn   = (i % 2) == 1;
      ifa.reset_btn = (i % 2) == 0;
      cyc(1);
    end
    ifa.set_btn = 1'b0; ifa.reset_btn = 1'b0;
    cyc(15);
    check("conflict_a_bounce", {31'd0, ifa.conflict}, 32'd0);

    // Simultaneous press, reset priority
    ed = edge_cnt + 1;
    ifa.set_btn = 1'b1; ifa.reset_btn = 1'b1;
    push(0, 1'b1, ed + 6, 1);
    cyc(6);
    check("conflict_a_before", {31'd0, ifa.conflict}, 32'd0);
    cyc(1);
    check("conflict_a_after", {31'd0, ifa.conflict}, 32'd1);
    check("busy_a_pulse", {31'd0, ifa.busy}, 32'd1);
    cyc(10);
    ifa.set_btn = 1'b0; ifa.reset_btn = 1'b0;
    cyc(15);

    // Simultaneous press, set priority
    ed = edge_cnt + 1;
    ifb.set_btn = 1'b1; ifb.reset_btn = 1'b1;
    push(1, 1'b0, ed + 6, 1);
    cyc(6);
    check("conflict_b_before", {31'd0, ifb.conflict}, 32'd0);
    cyc(1);
    check("conflict_b_after", {31'd0, ifb.conflict}, 32'd1);
    cyc(10);
    ifb.set_btn = 1'b0; ifb.reset_btn = 1'b0;
    cyc(15);

    // Reset request during set pulse is served after the gap
    ed = edge_cnt + 1;
    ifa.set_btn = 1'b1;
    push(0, 1'b0, ed + 6, 1);
    push(0, 1'b1, ed + 8, 1);
    cyc(1);
    ifa.reset_btn = 1'b1;
    cyc(12);
    ifa.set_btn = 1'b0; ifa.reset_btn = 1'b0;
    cyc(15);

    // Same with three-cycle pulses
    ed = edge_cnt + 1;
    ifc.set_btn = 1'b1;
    push(2, 1'b0, ed + 6, 3);
    push(2, 1'b1, ed + 10, 3);
    cyc(1);
    ifc.reset_btn = 1'b1;
    cyc(16);
    ifc.set_btn = 1'b0; ifc.reset_btn = 1'b0;
    cyc(15);
    check("conflict_c_serial", {31'd0, ifc.conflict}, 32'd0);

    // Reset mid-pulse with reset request pending, set still held
    ed = edge_cnt + 1;
    ifc.set_btn = 1'b1;
    push(2, 1'b0, ed + 6, 2);
    cyc(1);
    ifc.reset_btn = 1'b1;
    cyc(6);
    ifc.reset_btn = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("midrst_c", {28'd0, ifc.s, ifc.r, ifc.busy, ifc.conflict}, 32'd0);
    check("midrst_conflict_a", {31'd0, ifa.conflict}, 32'd0);
    check("midrst_conflict_b", {31'd0, ifb.conflict}, 32'd0);
    rst = 1'b0;
    rel = edge_cnt;
    push(2, 1'b0, rel + 7, 3);
    cyc(20);
    ifc.set_btn = 1'b0;
    cyc(15);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: got %0d outstanding pulses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
